axi_sim_mem: RTL

Parametrised AXI4 slave memory model for the Verilator testbench: it replaces the tied-off `M_AXI` (and optionally `M_AXI_MMIO`) master ports of `rocketchip_wrapper` with a live, burst-capable RAM that answers reads and writes. Read and write channels run independent state machines, each with one outstanding transaction. It returns DECERR outside its window and can inject pseudo-random back-pressure to stress the core's AXI master.

---
 rtl/axi_sim_mem.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_sim_mem.sv
// AXI4 slave RAM model with independent read/write FSMs and DECERR outside its window.
// Define AXI_SIM_MEM_BACKPRESSURE_EN for LFSR-driven pseudo-random stalls.
module axi_sim_mem #(
  parameter int unsigned          ADDR_WIDTH  = 32,
  parameter int unsigned          DATA_WIDTH  = 64,
  parameter int unsigned          ID_WIDTH    = 4,
  parameter int unsigned          DEPTH_WORDS = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    S_AXI_awvalid,
  output logic                    S_AXI_awready,
  input  logic [ID_WIDTH-1:0]     S_AXI_awid,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
  input  logic [7:0]              S_AXI_awlen,
  input  logic [2:0]              S_AXI_awsize,
  input  logic [1:0]              S_AXI_awburst,

  input  logic                    S_AXI_wvalid,
  output logic                    S_AXI_wready,
  input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
  input  logic                    S_AXI_wlast,

  output logic                    S_AXI_bvalid,
  input  logic                    S_AXI_bready,
  output logic [ID_WIDTH-1:0]     S_AXI_bid,
  output logic [1:0]              S_AXI_bresp,

  input  logic                    S_AXI_arvalid,
  output logic                    S_AXI_arready,
  input  logic [ID_WIDTH-1:0]     S_AXI_arid,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
  input  logic [7:0]              S_AXI_arlen,
  input  logic [2:0]              S_AXI_arsize,
  input  logic [1:0]              S_AXI_arburst,

  output logic                    S_AXI_rvalid,
  input  logic                    S_AXI_rready,
  output logic [ID_WIDTH-1:0]     S_AXI_rid,
  output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
  output logic [1:0]              S_AXI_rresp,
  output logic                    S_AXI_rlast
);

  localparam int unsigned StrbW    = DATA_WIDTH / 8;
  localparam int unsigned OffBits  = $clog2(StrbW);
  localparam int unsigned IdxBits  = $clog2(DEPTH_WORDS);
  localparam int unsigned SpanBits = OffBits + IdxBits;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;
  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  // BASE_ADDR is span-aligned, so the window test is a compare of the upper bits.
  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:SpanBits] == BASE_ADDR[ADDR_WIDTH-1:SpanBits];
  endfunction

  function automatic logic [IdxBits-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return a[SpanBits-1:OffBits];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0]            len,
                                                      input logic [2:0]            size,
                                                      input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] res;
    step      = ADDR_WIDTH'(1) << size;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    unique case (burst)
      BurstFixed: res = a;
      BurstWrap:  res = (a & ~wrap_mask) | ((a + step) & wrap_mask);
      default:    res = a + step;
    endcase
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic stall;
`ifdef AXI_SIM_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clock) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Write channel
  w_state_e              w_state_q;
  logic [ID_WIDTH-1:0]   aw_id_q;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [7:0]            aw_len_q;
  logic [2:0]            aw_size_q;
  logic [1:0]            aw_burst_q;
  logic [7:0]            w_cnt_q;
  logic                  dec_err_q;
  logic                  slv_err_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic       aw_hs;
  logic       w_beat;
  logic       beat_dec;
  logic       beat_slv;
  logic [1:0] bresp_d;

  assign aw_hs    = S_AXI_awvalid && S_AXI_awready;
  assign w_beat   = S_AXI_wvalid && S_AXI_wready;
  assign beat_dec = !in_window(aw_addr_q);
  assign beat_slv = S_AXI_wlast != (w_cnt_q == aw_len_q);
  assign bresp_d  = (dec_err_q || beat_dec) ? RespDecErr :
                    (slv_err_q || beat_slv) ? RespSlvErr : RespOkay;

  always_ff @(posedge clock) begin
    if (!reset) begin
      w_state_q  <= WIdle;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      dec_err_q  <= 1'b0;
      slv_err_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (aw_hs) begin
            aw_id_q    <= S_AXI_awid;
            aw_addr_q  <= S_AXI_awaddr;
            aw_len_q   <= S_AXI_awlen;
            aw_size_q  <= S_AXI_awsize;
            aw_burst_q <= S_AXI_awburst;
            w_cnt_q    <= '0;
            dec_err_q  <= 1'b0;
            slv_err_q  <= (S_AXI_awburst == BurstRsvd);
            w_state_q  <= WData;
          end
        end
        WData: begin
          if (w_beat) begin
            if (beat_dec) dec_err_q <= 1'b1;
            if (beat_slv) slv_err_q <= 1'b1;
            aw_addr_q <= next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
            w_cnt_q   <= w_cnt_q + 8'd1;
            if (w_cnt_q == aw_len_q) begin
              bresp_q   <= bresp_d;
              bvalid_q  <= !stall;
              w_state_q <= WResp;
            end
          end
        end
        WResp: begin
          if (!bvalid_q) begin
            if (!stall) bvalid_q <= 1'b1;
          end else if (S_AXI_bready) begin
            bvalid_q  <= 1'b0;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_beat && !beat_dec) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (S_AXI_wstrb[b]) mem[word_idx(aw_addr_q)][8*b +: 8] <= S_AXI_wdata[8*b +: 8];
      end
    end
  end

  // Read channel
  r_state_e              r_state_q;
  logic [ID_WIDTH-1:0]   ar_id_q;
  logic [ADDR_WIDTH-1:0] ar_addr_q;
  logic [7:0]            ar_len_q;
  logic [2:0]            ar_size_q;
  logic [1:0]            ar_burst_q;
  logic [7:0]            r_cnt_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  logic                  ar_hs;
  logic [ADDR_WIDTH-1:0] r_fetch_addr;
  logic [1:0]            r_fetch_burst;
  logic [DATA_WIDTH-1:0] r_fetch_data;
  logic [1:0]            r_fetch_resp;

  assign ar_hs = S_AXI_arvalid && S_AXI_arready;

  // Fetch address is the AR address when idle, else the next beat's address.
  always_comb begin
    r_fetch_addr  = S_AXI_araddr;
    r_fetch_burst = S_AXI_arburst;
    if (r_state_q == RData) begin
      r_fetch_addr  = next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
      r_fetch_burst = ar_burst_q;
    end
    r_fetch_data = '0;
    r_fetch_resp = RespDecErr;
    if (in_window(r_fetch_addr)) begin
      r_fetch_data = mem[word_idx(r_fetch_addr)];
      r_fetch_resp = (r_fetch_burst == BurstRsvd) ? RespSlvErr : RespOkay;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state_q  <= RIdle;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      rlast_q    <= 1'b0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (ar_hs) begin
            ar_id_q    <= S_AXI_arid;
            ar_addr_q  <= S_AXI_araddr;
            ar_len_q   <= S_AXI_arlen;
            ar_size_q  <= S_AXI_arsize;
            ar_burst_q <= S_AXI_arburst;
            r_cnt_q    <= '0;
            rdata_q    <= r_fetch_data;
            rresp_q    <= r_fetch_resp;
            rlast_q    <= (S_AXI_arlen == 8'd0);
            rvalid_q   <= !stall;
            r_state_q  <= RData;
          end
        end
        RData: begin
          if (!rvalid_q) begin
            if (!stall) rvalid_q <= 1'b1;
          end else if (S_AXI_rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              r_state_q <= RIdle;
            end else begin
              ar_addr_q <= r_fetch_addr;
              r_cnt_q   <= r_cnt_q + 8'd1;
              rdata_q   <= r_fetch_data;
              rresp_q   <= r_fetch_resp;
              rlast_q   <= (r_cnt_q + 8'd1) == ar_len_q;
              rvalid_q  <= !stall;
            end
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  // Outputs are forced low for as long as reset is held.
  assign S_AXI_awready = reset && (w_state_q == WIdle) && !stall;
  assign S_AXI_wready  = reset && (w_state_q == WData) && !stall;
  assign S_AXI_bvalid  = reset && bvalid_q;
  assign S_AXI_bid     = reset ? aw_id_q : '0;
  assign S_AXI_bresp   = reset ? bresp_q : '0;
  assign S_AXI_arready = reset && (r_state_q == RIdle) && !stall;
  assign S_AXI_rvalid  = reset && rvalid_q;
  assign S_AXI_rid     = reset ? ar_id_q : '0;
  assign S_AXI_rdata   = reset ? rdata_q : '0;
  assign S_AXI_rresp   = reset ? rresp_q : '0;
  assign S_AXI_rlast   = reset && rlast_q;

endmodule
